// File: rtl/piece_scheduler.sv
// piece_scheduler: filters raw 2-bit random values into piece codes 0..2, caps
//    identical-piece runs at MAX_RUN, and queues upcoming pieces in a DEPTH-entry FIFO.
// Latency: rnd sampled at edge t is in the queue from cycle t+1; a pop takes effect on the sampling edge.
// Backpressure: when FULL, a new piece is accepted only in a cycle that also pops; otherwise rnd is dropped.
// Ports: clk/rst_n (async active-low); rnd raw random input; spawn_req takes the head piece;
//    restart flushes the queue and counters; piece/piece_valid head entry; preview/preview_valid
//    second entry; level occupancy; underrun sticky empty-request flag; spawned_cnt delivered pieces.
module piece_scheduler #(
   parameter int DEPTH   = 4,
   parameter int MAX_RUN = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  rnd,
   input  logic        spawn_req,
   input  logic        restart,
   output logic [1:0]  piece,
   output logic        piece_valid,
   output logic [1:0]  preview,
   output logic        preview_valid,
   output logic [3:0]  level,
   output logic        underrun,
   output logic [15:0] spawned_cnt
);

   localparam int              PW        = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
   localparam logic [3:0]      DEPTH_L   = 4'(DEPTH);
   localparam logic [1:0]      MAX_RUN_L = 2'(MAX_RUN);
   localparam logic [PW-1:0]   LAST_IDX  = PW'(DEPTH - 1);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      FULL  = 2'd2
   } q_state_t;

   q_state_t        state;
   logic [1:0]      mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_next_ptr;
   logic [1:0]      last;
   logic [1:0]      run_len;
   logic [1:0]      next_last;
   logic [1:0]      push_val;
   logic            pop;
   logic            push;
   logic            same;
   logic            hit_limit;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_IDX) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      state = FILL;
      if (level == 4'd0) begin
         state = EMPTY;
      end else if (level == DEPTH_L) begin
         state = FULL;
      end
   end

   assign pop       = spawn_req && (state != EMPTY);
   // A FULL queue still accepts a piece when the head leaves in the same cycle.
   assign push      = (rnd != 2'd3) && ((state != FULL) || pop);
   assign same      = (rnd == last);
   assign hit_limit = same && (run_len == MAX_RUN_L);
   // Substitute piece when the run is exhausted: the next code, wrapping 2 -> 0.
   assign next_last = (last == 2'd2) ? 2'd0 : last + 2'd1;
   assign push_val  = hit_limit ? next_last : rnd;

   assign rd_next_ptr   = ptr_inc(rd_ptr);
   assign piece         = mem[rd_ptr];
   assign preview       = mem[rd_next_ptr];
   assign piece_valid   = (state != EMPTY);
   assign preview_valid = (level >= 4'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         level       <= '0;
         last        <= '0;
         run_len     <= '0;
         underrun    <= 1'b0;
         spawned_cnt <= '0;
      end else if (restart) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         level       <= '0;
         last        <= '0;
         run_len     <= '0;
         underrun    <= 1'b0;
         spawned_cnt <= '0;
      end else begin
         if (spawn_req && (state == EMPTY)) begin
            underrun <= 1'b1;
         end
         if (pop) begin
            rd_ptr      <= rd_next_ptr;
            spawned_cnt <= spawned_cnt + 16'd1;
         end
         if (push) begin
            mem[wr_ptr] <= push_val;
            wr_ptr      <= ptr_inc(wr_ptr);
            last        <= push_val;
            run_len     <= (same && !hit_limit) ? run_len + 2'd1 : 2'd1;
         end
         if (push && !pop) begin
            level <= level + 4'd1;
         end else if (pop && !push) begin
            level <= level - 4'd1;
         end
      end
   end

endmodule
